inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: 16-entry instruction fetch queue between fetch and decode.
// Accepts up to four instruction slots per cycle (compacted by enable mask) and
// presents two head entries to decode, which consumes 0..2 per cycle.
// Optional build macro IFQ_PERF_CNT_EN adds IFQ_emptyCycles_o, a saturating
// count of non-flush cycles spent with the queue empty.
module inst_fetch_queue (
    input  logic         clk,
    input  logic         rst,
    input  logic         SCT_valid_i,
    input  logic [31:0]  SCT_VAddr_i,
    input  logic [3:0]   SCT_originEnable_i,
    input  logic [127:0] inst_rdata_i,
    input  logic         SCT_hasException_i,
    input  logic [4:0]   SCT_ExcCode_i,
    input  logic         SCT_isRefill_i,
    output logic         IFQ_allowin_w_o,
    input  logic         flush_w_i,
    input  logic [1:0]   ID_accept_i,
    output logic [1:0]   IFQ_valid_o,
    output logic [63:0]  IFQ_inst_o,
    output logic [63:0]  IFQ_pc_o,
    output logic [1:0]   IFQ_exc_o,
    output logic [1:0]   IFQ_isRefill_o,
`ifdef IFQ_PERF_CNT_EN
    output logic [31:0]  IFQ_emptyCycles_o,
`endif
    output logic [9:0]   IFQ_ExcCode_o
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
        logic        refill;
        logic [4:0]  code;
    } entry_t;

    entry_t      ram_q [16];
    logic [3:0]  head_q, head_d, tail_q, tail_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        push;
    logic [2:0]  push_n;
    logic [1:0]  acc, pop_n;
    logic [1:0]  off [4];
    entry_t      h0, h1;
    logic        v0, v1;

    // Full-packet acceptance is judged on the registered count only.
    assign IFQ_allowin_w_o = (cnt_q <= 5'd12);
    assign push = SCT_valid_i && IFQ_allowin_w_o && !flush_w_i;

    // Slot compaction: each enabled slot lands at tail + number of enabled slots below it.
    always_comb begin
        push_n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            off[i] = push_n[1:0];
            push_n = push_n + {2'b00, SCT_originEnable_i[i]};
        end
        // An empty mask with an exception still pushes one exception-carrying entry.
        if (SCT_originEnable_i == 4'b0000 && SCT_hasException_i)
            push_n = 3'd1;
    end

    // Decode may ask for more than is present; clamp to 2 and to the current count.
    always_comb begin
        acc   = (ID_accept_i == 2'd3) ? 2'd2 : ID_accept_i;
        pop_n = ({3'b000, acc} > cnt_q) ? cnt_q[1:0] : acc;
    end

    // Pointer/count next state; flush overrides any push or pop.
    always_comb begin
        head_d = head_q + {2'b00, pop_n};
        tail_d = push ? tail_q + {1'b0, push_n} : tail_q;
        cnt_d  = cnt_q + (push ? {2'b00, push_n} : 5'd0) - {3'b000, pop_n};
        if (flush_w_i) begin
            head_d = 4'd0;
            tail_d = 4'd0;
            cnt_d  = 5'd0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= 4'd0;
            tail_q <= 4'd0;
            cnt_q  <= 5'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care until covered by count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            if (SCT_originEnable_i == 4'b0000) begin
                if (SCT_hasException_i)
                    ram_q[tail_q] <= '{inst: 32'd0, pc: SCT_VAddr_i, exc: 1'b1,
                                       refill: SCT_isRefill_i, code: SCT_ExcCode_i};
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (SCT_originEnable_i[i]) begin
                        // Only the first enabled slot (offset 0) carries the exception.
                        ram_q[tail_q + {2'b00, off[i]}] <= '{
                            inst:   inst_rdata_i[32*i +: 32],
                            pc:     SCT_VAddr_i + 32'(4 * i),
                            exc:    SCT_hasException_i && (off[i] == 2'd0),
                            refill: SCT_hasException_i && (off[i] == 2'd0) && SCT_isRefill_i,
                            code:   (SCT_hasException_i && (off[i] == 2'd0)) ? SCT_ExcCode_i : 5'd0};
                    end
                end
            end
        end
    end

    // Head read: combinational, with invalid heads forced to zero.
    always_comb begin
        h0 = ram_q[head_q];
        h1 = ram_q[head_q + 4'd1];
        v0 = (cnt_q != 5'd0);
        v1 = (cnt_q >= 5'd2);
        IFQ_valid_o    = {v1, v0};
        IFQ_inst_o     = {v1 ? h1.inst : 32'd0, v0 ? h0.inst : 32'd0};
        IFQ_pc_o       = {v1 ? h1.pc : 32'd0, v0 ? h0.pc : 32'd0};
        IFQ_exc_o      = {v1 & h1.exc, v0 & h0.exc};
        IFQ_isRefill_o = {v1 & h1.refill, v0 & h0.refill};
        IFQ_ExcCode_o  = {v1 ? h1.code : 5'd0, v0 ? h0.code : 5'd0};
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] empty_cnt_q;
    assign IFQ_emptyCycles_o = empty_cnt_q;

    // Saturating count of empty, non-flush cycles; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            empty_cnt_q <= 32'd0;
        else if (cnt_q == 5'd0 && !flush_w_i && empty_cnt_q != 32'hFFFF_FFFF)
            empty_cnt_q <= empty_cnt_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue; also covers IFQ_emptyCycles_o when
// built with IFQ_PERF_CNT_EN.
module tb_inst_fetch_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         SCT_valid_i = 1'b0;
    logic [31:0]  SCT_VAddr_i = '0;
    logic [3:0]   SCT_originEnable_i = '0;
    logic [127:0] inst_rdata_i = '0;
    logic         SCT_hasException_i = 1'b0;
    logic [4:0]   SCT_ExcCode_i = '0;
    logic         SCT_isRefill_i = 1'b0;
    logic         IFQ_allowin_w_o;
    logic         flush_w_i = 1'b0;
    logic [1:0]   ID_accept_i = '0;
    logic [1:0]   IFQ_valid_o;
    logic [63:0]  IFQ_inst_o, IFQ_pc_o;
    logic [1:0]   IFQ_exc_o, IFQ_isRefill_o;
    logic [9:0]   IFQ_ExcCode_o;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0]  IFQ_emptyCycles_o;
`endif

    int vecs = 0;
    int errs = 0;

    inst_fetch_queue dut (
        .clk(clk), .rst(rst),
        .SCT_valid_i(SCT_valid_i), .SCT_VAddr_i(SCT_VAddr_i),
        .SCT_originEnable_i(SCT_originEnable_i), .inst_rdata_i(inst_rdata_i),
        .SCT_hasException_i(SCT_hasException_i), .SCT_ExcCode_i(SCT_ExcCode_i),
        .SCT_isRefill_i(SCT_isRefill_i), .IFQ_allowin_w_o(IFQ_allowin_w_o),
        .flush_w_i(flush_w_i), .ID_accept_i(ID_accept_i),
        .IFQ_valid_o(IFQ_valid_o), .IFQ_inst_o(IFQ_inst_o), .IFQ_pc_o(IFQ_pc_o),
        .IFQ_exc_o(IFQ_exc_o), .IFQ_isRefill_o(IFQ_isRefill_o),
`ifdef IFQ_PERF_CNT_EN
        .IFQ_emptyCycles_o(IFQ_emptyCycles_o),
`endif
        .IFQ_ExcCode_o(IFQ_ExcCode_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        SCT_valid_i = 1'b0; SCT_originEnable_i = '0; SCT_hasException_i = 1'b0;
        SCT_ExcCode_i = '0; SCT_isRefill_i = 1'b0; ID_accept_i = '0; flush_w_i = 1'b0;
    endtask

    task automatic push_pkt(input logic [31:0] base, input logic [3:0] m, input logic [127:0] d,
                            input logic e, input logic [4:0] c, input logic r);
        SCT_valid_i = 1'b1; SCT_VAddr_i = base; SCT_originEnable_i = m; inst_rdata_i = d;
        SCT_hasException_i = e; SCT_ExcCode_i = c; SCT_isRefill_i = r;
        tick;
        clear_in;
    endtask

    task automatic pop(input logic [1:0] a);
        ID_accept_i = a;
        tick;
        ID_accept_i = '0;
    endtask

    // Pops everything present (bounded), returning entry count and last PC seen.
    task automatic drain(output int n, output logic [31:0] last);
        n = 0; last = '0;
        for (int k = 0; k < 20 && IFQ_valid_o != 2'b00; k++) begin
            if (IFQ_valid_o[1]) last = IFQ_pc_o[63:32];
            else                last = IFQ_pc_o[31:0];
            n += int'(IFQ_valid_o[0]) + int'(IFQ_valid_o[1]);
            ID_accept_i = 2'd2;
            tick;
        end
        ID_accept_i = '0;
    endtask

    task automatic test_reset;
        // a packet presented during reset must not be retained
        push_pkt(32'hDEAD_0000, 4'hF, {4{32'h5555_AAAA}}, 1'b1, 5'h3, 1'b1);
        SCT_valid_i = 1'b1; SCT_originEnable_i = 4'hF;
        vecs++; if (IFQ_valid_o !== 2'b00) begin errs++; $display("FAIL reset_valid got %b exp 00", IFQ_valid_o); end
        vecs++; if (IFQ_allowin_w_o !== 1'b1) begin errs++; $display("FAIL reset_allowin got %b exp 1", IFQ_allowin_w_o); end
        vecs++; if (IFQ_pc_o !== 64'd0 || IFQ_inst_o !== 64'd0) begin errs++; $display("FAIL reset_data got pc %h inst %h exp 0", IFQ_pc_o, IFQ_inst_o); end
        vecs++; if (IFQ_exc_o !== 2'b00 || IFQ_ExcCode_o !== 10'd0 || IFQ_isRefill_o !== 2'b00) begin errs++; $display("FAIL reset_exc got %b %h %b exp 0", IFQ_exc_o, IFQ_ExcCode_o, IFQ_isRefill_o); end
        clear_in;
        rst = 1'b1;
        tick;
        vecs++; if (IFQ_valid_o !== 2'b00) begin errs++; $display("FAIL post_reset_empty got %b exp 00", IFQ_valid_o); end
    endtask

    task automatic test_full_packet;
        push_pkt(32'h1000, 4'b1111, 128'h33333333_22222222_11111111_00000000, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_valid_o !== 2'b11) begin errs++; $display("FAIL full_valid got %b exp 11", IFQ_valid_o); end
        vecs++; if (IFQ_pc_o !== {32'h1004, 32'h1000}) begin errs++; $display("FAIL full_pc got %h exp 0000100400001000", IFQ_pc_o); end
        vecs++; if (IFQ_inst_o !== 64'h11111111_00000000) begin errs++; $display("FAIL full_inst got %h exp 1111111100000000", IFQ_inst_o); end
        pop(2'd2);
        vecs++; if (IFQ_pc_o !== {32'h100C, 32'h1008} || IFQ_inst_o !== 64'h33333333_22222222) begin errs++; $display("FAIL full_pop2 got pc %h inst %h", IFQ_pc_o, IFQ_inst_o); end
        pop(2'd2);
        vecs++; if (IFQ_valid_o !== 2'b00) begin errs++; $display("FAIL full_empty got %b exp 00", IFQ_valid_o); end
    endtask

    task automatic test_sparse_mask;
        push_pkt(32'h2000, 4'b1010, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_valid_o !== 2'b11 || IFQ_pc_o !== {32'h200C, 32'h2004}) begin errs++; $display("FAIL sparse_pc got v %b pc %h exp 11 0000200C00002004", IFQ_valid_o, IFQ_pc_o); end
        vecs++; if (IFQ_inst_o !== 64'hA3A3A3A3_A1A1A1A1) begin errs++; $display("FAIL sparse_inst got %h exp A3A3A3A3A1A1A1A1", IFQ_inst_o); end
        pop(2'd1);
        vecs++; if (IFQ_valid_o !== 2'b01 || IFQ_pc_o !== 64'h0000_0000_0000_200C) begin errs++; $display("FAIL sparse_one got v %b pc %h exp 01 200C", IFQ_valid_o, IFQ_pc_o); end
        pop(2'd1);
        vecs++; if (IFQ_valid_o !== 2'b00) begin errs++; $display("FAIL sparse_empty got %b exp 00", IFQ_valid_o); end
    endtask

    task automatic test_zero_mask;
        push_pkt(32'h3100, 4'b0000, {4{32'hFFFF_FFFF}}, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_valid_o !== 2'b00) begin errs++; $display("FAIL zero_noexc got %b exp 00", IFQ_valid_o); end
        push_pkt(32'h3000, 4'b0000, {4{32'hFFFF_FFFF}}, 1'b1, 5'h04, 1'b0);
        vecs++; if (IFQ_valid_o !== 2'b01 || IFQ_pc_o !== 64'h3000 || IFQ_inst_o !== 64'd0) begin errs++; $display("FAIL zero_exc_entry got v %b pc %h inst %h", IFQ_valid_o, IFQ_pc_o, IFQ_inst_o); end
        vecs++; if (IFQ_exc_o !== 2'b01 || IFQ_ExcCode_o !== 10'h004 || IFQ_isRefill_o !== 2'b00) begin errs++; $display("FAIL zero_exc_flags got %b %h %b exp 01 004 00", IFQ_exc_o, IFQ_ExcCode_o, IFQ_isRefill_o); end
        pop(2'd1);
    endtask

    task automatic test_exc_first_only;
        push_pkt(32'h6000, 4'b0110, 128'h0, 1'b1, 5'h0C, 1'b1);
        vecs++; if (IFQ_valid_o !== 2'b11 || IFQ_pc_o !== {32'h6008, 32'h6004}) begin errs++; $display("FAIL excfirst_pc got v %b pc %h", IFQ_valid_o, IFQ_pc_o); end
        vecs++; if (IFQ_exc_o !== 2'b01 || IFQ_isRefill_o !== 2'b01 || IFQ_ExcCode_o !== 10'h00C) begin errs++; $display("FAIL excfirst_flags got %b %b %h exp 01 01 00C", IFQ_exc_o, IFQ_isRefill_o, IFQ_ExcCode_o); end
        pop(2'd2);
    endtask

    task automatic test_backpressure;
        int n; logic [31:0] last;
        push_pkt(32'h4000, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'h4010, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'h4020, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_allowin_w_o !== 1'b1) begin errs++; $display("FAIL bp_allow12 got %b exp 1", IFQ_allowin_w_o); end
        push_pkt(32'h4030, 4'b0001, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_allowin_w_o !== 1'b0) begin errs++; $display("FAIL bp_allow13 got %b exp 0", IFQ_allowin_w_o); end
        push_pkt(32'h5000, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_allowin_w_o !== 1'b0) begin errs++; $display("FAIL bp_ignored got %b exp 0", IFQ_allowin_w_o); end
        pop(2'd2);
        vecs++; if (IFQ_allowin_w_o !== 1'b1) begin errs++; $display("FAIL bp_allow11 got %b exp 1", IFQ_allowin_w_o); end
        drain(n, last);
        vecs++; if (n != 11 || last !== 32'h4030) begin errs++; $display("FAIL bp_drain got n %0d last %h exp 11 4030", n, last); end
    endtask

    task automatic test_clamp_and_concurrent;
        int n; logic [31:0] last;
        push_pkt(32'h7000, 4'b0001, 128'h0, 1'b0, 5'd0, 1'b0);
        pop(2'd3);
        vecs++; if (IFQ_valid_o !== 2'b00 || IFQ_allowin_w_o !== 1'b1) begin errs++; $display("FAIL clamp got v %b allow %b exp 00 1", IFQ_valid_o, IFQ_allowin_w_o); end
        push_pkt(32'h7100, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_pc_o !== {32'h7104, 32'h7100}) begin errs++; $display("FAIL clamp_next got %h exp 0000710400007100", IFQ_pc_o); end
        ID_accept_i = 2'd2;
        push_pkt(32'h7200, 4'b0011, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_pc_o !== {32'h710C, 32'h7108}) begin errs++; $display("FAIL pushpop_head got %h exp 0000710C00007108", IFQ_pc_o); end
        drain(n, last);
        vecs++; if (n != 4 || last !== 32'h7204) begin errs++; $display("FAIL pushpop_drain got n %0d last %h exp 4 7204", n, last); end
    endtask

    task automatic test_flush_wrap;
        int n; logic [31:0] last;
        flush_w_i = 1'b1; tick; flush_w_i = 1'b0;
        push_pkt(32'h8000, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'h8010, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'h8020, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'h8030, 4'b0011, 128'h0, 1'b0, 5'd0, 1'b0);
        drain(n, last);
        vecs++; if (n != 14 || last !== 32'h8034) begin errs++; $display("FAIL wrap_pre_drain got n %0d last %h exp 14 8034", n, last); end
        for (int p = 0; p < 4; p++) push_pkt(32'h9000 + 32'(16 * p), 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_allowin_w_o !== 1'b0 || IFQ_valid_o !== 2'b11 || IFQ_pc_o !== {32'h9004, 32'h9000}) begin errs++; $display("FAIL full16 got allow %b v %b pc %h", IFQ_allowin_w_o, IFQ_valid_o, IFQ_pc_o); end
        flush_w_i = 1'b1; ID_accept_i = 2'd2;
        push_pkt(32'hAAAA_0000, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_valid_o !== 2'b00 || IFQ_allowin_w_o !== 1'b1) begin errs++; $display("FAIL flush got v %b allow %b exp 00 1", IFQ_valid_o, IFQ_allowin_w_o); end
        push_pkt(32'h9F00, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_pc_o !== {32'h9F04, 32'h9F00}) begin errs++; $display("FAIL post_flush_push got %h exp 00009F0400009F00", IFQ_pc_o); end
        drain(n, last);
        vecs++; if (n != 4) begin errs++; $display("FAIL post_flush_drain got %0d exp 4", n); end
    endtask

    task automatic test_head_wrap;
        int n; logic [31:0] last;
        flush_w_i = 1'b1; tick; flush_w_i = 1'b0;
        push_pkt(32'hB000, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'hB010, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'hB020, 4'hF, 128'h0, 1'b0, 5'd0, 1'b0);
        push_pkt(32'hB030, 4'b0111, 128'h0, 1'b0, 5'd0, 1'b0);
        drain(n, last);
        vecs++; if (n != 15) begin errs++; $display("FAIL hwrap_pre got %0d exp 15", n); end
        push_pkt(32'hA000, 4'b0011, 128'h0_0_C1C1C1C1_C0C0C0C0, 1'b0, 5'd0, 1'b0);
        vecs++; if (IFQ_valid_o !== 2'b11 || IFQ_pc_o !== {32'hA004, 32'hA000} || IFQ_inst_o !== 64'hC1C1C1C1_C0C0C0C0) begin errs++; $display("FAIL hwrap_read got v %b pc %h inst %h", IFQ_valid_o, IFQ_pc_o, IFQ_inst_o); end
        drain(n, last);
    endtask

`ifdef IFQ_PERF_CNT_EN
    task automatic test_perf;
        rst = 1'b0; tick; rst = 1'b1;
        repeat (10) tick;
        vecs++; if (IFQ_emptyCycles_o !== 32'd10) begin errs++; $display("FAIL perf_idle got %0d exp 10", IFQ_emptyCycles_o); end
        flush_w_i = 1'b1; repeat (3) tick; flush_w_i = 1'b0;
        vecs++; if (IFQ_emptyCycles_o !== 32'd10) begin errs++; $display("FAIL perf_flush got %0d exp 10", IFQ_emptyCycles_o); end
    endtask
`endif

    initial begin
        tick; tick;
        test_reset;
        test_full_packet;
        test_sparse_mask;
        test_zero_mask;
        test_exc_first_only;
        test_backpressure;
        test_clamp_and_concurrent;
        test_flush_wrap;
        test_head_wrap;
`ifdef IFQ_PERF_CNT_EN
        test_perf;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
